adxl355_sync_drdy_multi: RTL

//  Multi-channel successor to the single-channel ADXL355 sync/drdy generator.

---
 rtl/adxl355_sync_drdy_multi.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/adxl355_sync_drdy_multi.sv
// Shared extended sync with holdover and per-channel delayed drdy pulses.
// One 1 kHz sync source fans out to several ADXL355 SPI readers.
module adxl355_sync_drdy_multi #(
   parameter int CLK_HZ        = 40000000,
   parameter int CHANNELS      = 2,
   parameter int SYNC_WIDTH_US = 20,
   parameter int PERIOD_US     = 1000,
   parameter int TIMING_BITS   = 20
) (
   input  logic                            i_clk,
   input  logic                            i_rst,
   input  logic                            i_clk_sync,
   input  logic                            i_holdover_en,
   input  logic [CHANNELS*TIMING_BITS-1:0] i_drdy_delay,
   output logic                            o_clk_sync,
   output logic [CHANNELS-1:0]             o_clk_drdy,
   output logic                            o_sync_lost,
   output logic                            o_sync_int,
   output logic [15:0]                     o_sync_count
);

   localparam int TB = TIMING_BITS;
   localparam longint P_L = longint'(PERIOD_US) * longint'(CLK_HZ) / 1000000;
   localparam longint W_L = longint'(SYNC_WIDTH_US) * longint'(CLK_HZ) / 1000000;
   localparam int P = int'(P_L);
   localparam int W = int'(W_L);

   localparam logic [TB-1:0] P_M1   = TB'(P - 1);
   localparam logic [TB-1:0] L_M1   = TB'(P + P / 4 - 1);
   localparam logic [TB-1:0] WIN_LO = TB'(P - P / 4);
   localparam logic [TB-1:0] W_V    = TB'(W);

   typedef enum logic [1:0] {
      ST_ACQ,
      ST_LOCK,
      ST_LOST
   } state_t;

   state_t state_q, state_d;
   logic prior_q, prior_d;
   logic lost_q, lost_d;
   logic sync_int_q, sync_int_d;
   logic [TB-1:0] wd_q, wd_d;
   logic [TB-1:0] sync_cnt_q, sync_cnt_d;
   logic [15:0] count_q, count_d;
   logic [CHANNELS-1:0][TB-1:0] dly_q, dly_d;
   logic [CHANNELS-1:0] pend_q, pend_d;

   logic int_eff;
   logic eff;

   always_comb begin
      int_eff = (state_q == ST_LOST) && i_holdover_en && (wd_q == P_M1);
      eff = i_clk_sync | int_eff;
   end

   always_comb begin
      state_d = state_q;
      prior_d = prior_q;
      unique case (state_q)
         ST_ACQ: begin
            if (i_clk_sync) begin
               if (prior_q && (wd_q >= WIN_LO)) begin
                  state_d = ST_LOCK;
                  prior_d = 1'b0;
               end else begin
                  prior_d = 1'b1;
               end
            end else if (wd_q == L_M1) begin
               state_d = ST_LOST;
               prior_d = 1'b0;
            end
         end
         ST_LOCK: begin
            if (!i_clk_sync && (wd_q == L_M1)) begin
               state_d = ST_LOST;
            end
         end
         ST_LOST: begin
            if (i_clk_sync) begin
               state_d = ST_ACQ;
               prior_d = 1'b1;
            end
         end
         default: begin
            state_d = ST_ACQ;
            prior_d = 1'b0;
         end
      endcase
      lost_d = (state_d != ST_LOCK);
   end

   // Timeout restarts wd so holdover measures a full period from loss.
   always_comb begin
      wd_d = wd_q + TB'(1);
      if (eff || (wd_q == L_M1)) begin
         wd_d = '0;
      end
      sync_cnt_d = sync_cnt_q;
      if (eff) begin
         sync_cnt_d = W_V;
      end else if (sync_cnt_q != '0) begin
         sync_cnt_d = sync_cnt_q - TB'(1);
      end
      sync_int_d = eff ? !i_clk_sync : sync_int_q;
      count_d = count_q + 16'(eff);
   end

   always_comb begin
      dly_d = dly_q;
      pend_d = pend_q;
      o_clk_drdy = '0;
      for (int n = 0; n < CHANNELS; n++) begin
         o_clk_drdy[n] = pend_q[n] && (dly_q[n] == '0);
         if (eff) begin
            dly_d[n] = i_drdy_delay[n*TB +: TB];
            pend_d[n] = 1'b1;
         end else if (pend_q[n]) begin
            if (dly_q[n] == '0) begin
               pend_d[n] = 1'b0;
            end else begin
               dly_d[n] = dly_q[n] - TB'(1);
            end
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q    <= ST_ACQ;
         prior_q    <= 1'b0;
         lost_q     <= 1'b1;
         sync_int_q <= 1'b0;
         wd_q       <= '0;
         sync_cnt_q <= '0;
         count_q    <= '0;
         dly_q      <= '0;
         pend_q     <= '0;
      end else begin
         state_q    <= state_d;
         prior_q    <= prior_d;
         lost_q     <= lost_d;
         sync_int_q <= sync_int_d;
         wd_q       <= wd_d;
         sync_cnt_q <= sync_cnt_d;
         count_q    <= count_d;
         dly_q      <= dly_d;
         pend_q     <= pend_d;
      end
   end

   assign o_clk_sync   = (sync_cnt_q != '0);
   assign o_sync_lost  = lost_q;
   assign o_sync_int   = sync_int_q;
   assign o_sync_count = count_q;

endmodule
